clk_rst_seq: RTL and testbench



---
 rtl/clk_rst_pkg.sv | 40 ++++
 rtl/clk_rst_seq_if.sv | 35 +++
 rtl/sync_bit.sv | 25 ++
 rtl/clk_rst_seq.sv | 142 ++++++++++++++
 tb/tb_clk_rst_seq.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/clk_rst_pkg.sv
// Shared types and constants for the MMCM reset sequencer.
// State encoding, default timing constants and the counter sizing helper.
package clk_rst_pkg;

  typedef enum logic [2:0] {
    MMCM_RST  = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } seq_state_e;

  localparam int unsigned DEF_MMCM_RST_CYCLES = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT    = 65536;
  localparam int unsigned DEF_STABLE_CYCLES   = 1024;
  localparam int unsigned DEF_MAX_RETRIES     = 7;
  localparam int unsigned DEF_SYNC_STAGES     = 2;

  // Width that holds 0..max(a,b,c)-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    int unsigned w;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/clk_rst_seq_if.sv
// Status/control bundle between the reset sequencer and its MMCM/system side.
interface clk_rst_seq_if;

  logic       mmcm_locked;
  logic       soft_restart;
  logic       mmcm_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  modport master (
    input  mmcm_locked,
    input  soft_restart,
    output mmcm_rst,
    output sys_rst_n,
    output ready,
    output fail,
    output retry_cnt,
    output loss_cnt
  );

  modport slave (
    output mmcm_locked,
    output soft_restart,
    input  mmcm_rst,
    input  sys_rst_n,
    input  ready,
    input  fail,
    input  retry_cnt,
    input  loss_cnt
  );

endinterface

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with synchronous active-low reset.
module sync_bit #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= {STAGES{RST_VAL}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/clk_rst_seq.sv
// MMCM reset sequencer: pulses the MMCM reset, waits for a stable lock,
// then releases the system reset; retries on timeout and recovers from lock loss.
module clk_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int unsigned MMCM_RST_CYCLES = DEF_MMCM_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES   = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES     = DEF_MAX_RETRIES,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic          clk,
  input  logic          rst_n,
  clk_rst_seq_if.master bus
);

  localparam int unsigned     CW       = cnt_width(MMCM_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0]   RST_LAST = CW'(MMCM_RST_CYCLES - 1);
  localparam logic [CW-1:0]   TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]   STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  seq_state_e  state_r;
  seq_state_e  state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic [3:0]  retry_r;
  logic [3:0]  retry_nxt_s;
  logic [7:0]  loss_r;
  logic [7:0]  loss_nxt_s;
  logic        locked_sync_s;
  logic        mmcm_rst_r;
  logic        run_r;
  logic        fail_r;

  sync_bit #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.mmcm_locked),
    .q     (locked_sync_s)
  );

  // Next-state, retry/loss bookkeeping and shared counter; soft_restart overrides the FSM.
  always_comb begin
    state_nxt_s = state_r;
    retry_nxt_s = retry_r;
    loss_nxt_s  = loss_r;
    cnt_nxt_s   = cnt_r;
    if (bus.soft_restart) begin
      state_nxt_s = MMCM_RST;
      retry_nxt_s = 4'd0;
    end else begin
      case (state_r)
        MMCM_RST: begin
          if (cnt_r == RST_LAST) begin
            state_nxt_s = WAIT_LOCK;
          end else begin
            state_nxt_s = MMCM_RST;
          end
        end
        WAIT_LOCK: begin
          if (locked_sync_s) begin
            state_nxt_s = STABLE;
          end else if (cnt_r == TMO_LAST) begin
            if (32'(retry_r) < MAX_RETRIES) begin
              state_nxt_s = MMCM_RST;
              retry_nxt_s = (retry_r == 4'hF) ? retry_r : retry_r + 4'd1;
            end else begin
              state_nxt_s = FAIL;
            end
          end else begin
            state_nxt_s = WAIT_LOCK;
          end
        end
        STABLE: begin
          if (!locked_sync_s) begin
            state_nxt_s = WAIT_LOCK;
          end else if (cnt_r == STB_LAST) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = STABLE;
          end
        end
        RUN: begin
          if (!locked_sync_s) begin
            state_nxt_s = MMCM_RST;
            retry_nxt_s = 4'd0;
            loss_nxt_s  = (loss_r == 8'hFF) ? loss_r : loss_r + 8'd1;
          end else begin
            state_nxt_s = RUN;
          end
        end
        FAIL: begin
          state_nxt_s = FAIL;
        end
        default: begin
          state_nxt_s = MMCM_RST;
        end
      endcase
    end
    // A restart inside MMCM_RST keeps the state but must still clear the count.
    if (bus.soft_restart || (state_nxt_s != state_r)) begin
      cnt_nxt_s = '0;
    end else if ((state_r == MMCM_RST) || (state_r == WAIT_LOCK) || (state_r == STABLE)) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State, counters and outputs registered together so outputs track the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= MMCM_RST;
      cnt_r      <= '0;
      retry_r    <= 4'd0;
      loss_r     <= 8'd0;
      mmcm_rst_r <= 1'b1;
      run_r      <= 1'b0;
      fail_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      retry_r    <= retry_nxt_s;
      loss_r     <= loss_nxt_s;
      mmcm_rst_r <= (state_nxt_s == MMCM_RST);
      run_r      <= (state_nxt_s == RUN);
      fail_r     <= (state_nxt_s == FAIL);
    end
  end

  assign bus.mmcm_rst  = mmcm_rst_r;
  assign bus.sys_rst_n = run_r;
  assign bus.ready     = run_r;
  assign bus.fail      = fail_r;
  assign bus.retry_cnt = retry_r;
  assign bus.loss_cnt  = loss_r;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed scoreboard bench for clk_rst_seq: per-cycle expected output
// vectors are queued with the stimulus and compared one clock at a time.
module tb_clk_rst_seq;

  typedef struct {
    logic [15:0] v;
    string       tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;
  exp_t sb[$];

  clk_rst_seq_if bus ();

  clk_rst_seq #(
    .MMCM_RST_CYCLES (4),
    .LOCK_TIMEOUT    (32),
    .STABLE_CYCLES   (8),
    .MAX_RETRIES     (2),
    .SYNC_STAGES     (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs {mmcm_rst, sys_rst_n, ready, fail, retry_cnt, loss_cnt}.
  function automatic logic [15:0] vec(input logic mr, input logic run, input logic fl,
                                      input logic [3:0] rc, input logic [7:0] lc);
    return {mr, run, run, fl, rc, lc};
  endfunction

  task automatic exp_n(input int n, input logic [15:0] v, input string tag);
    for (int i = 0; i < n; i++) begin
      sb.push_back('{v: v, tag: tag});
    end
  endtask

  task automatic drain();
    exp_t        e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      obs = {bus.mmcm_rst, bus.sys_rst_n, bus.ready, bus.fail, bus.retry_cnt, bus.loss_cnt};
      n_vec++;
      assert (obs === e.v) else begin
        n_miss++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
      end
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n            = 1'b0;
    bus.soft_restart = 1'b0;
    bus.mmcm_locked  = 1'b0;
    exp_n(3, vec(1'b1, 1'b0, 1'b0, 4'd0, 8'd0), "reset_state");
    drain();

    // 1: normal lock
    rst_n = 1'b1;
    exp_n(3, vec(1'b1, 1'b0, 1'b0, 4'd0, 8'd0), "t1_mmcm_rst_pulse");
    exp_n(7, vec(1'b0, 1'b0, 1'b0, 4'd0, 8'd0), "t1_wait_lock");
    drain();
    bus.mmcm_locked = 1'b1;
    exp_n(10, vec(1'b0, 1'b0, 1'b0, 4'd0, 8'd0), "t1_stable_hold");
    exp_n(3,  vec(1'b0, 1'b1, 1'b0, 4'd0, 8'd0), "t1_run");
    drain();

    // 4: loss in RUN
    bus.mmcm_locked = 1'b0;
    exp_n(2, vec(1'b0, 1'b1, 1'b0, 4'd0, 8'd0), "t4_run_until_sync");
    exp_n(4, vec(1'b1, 1'b0, 1'b0, 4'd0, 8'd1), "t4_loss_mmcm_rst");
    exp_n(2, vec(1'b0, 1'b0, 1'b0, 4'd0, 8'd1), "t4_wait_relock");
    drain();
    bus.mmcm_locked = 1'b1;
    exp_n(10, vec(1'b0, 1'b0, 1'b0, 4'd0, 8'd1), "t4_relock_stable");
    exp_n(3,  vec(1'b0, 1'b1, 1'b0, 4'd0, 8'd1), "t4_run_again");
    drain();

    // 5b: soft_restart in RUN, then 3: glitch in STABLE
    bus.soft_restart = 1'b1;
    bus.mmcm_locked  = 1'b0;
    exp_n(1, vec(1'b1, 1'b0, 1'b0, 4'd0, 8'd1), "t5_soft_in_run");
    drain();
    bus.soft_restart = 1'b0;
    exp_n(3, vec(1'b1, 1'b0, 1'b0, 4'd0, 8'd1), "t5_run_restart_pulse");
    exp_n(2, vec(1'b0, 1'b0, 1'b0, 4'd0, 8'd1), "t3_wait");
    drain();
    bus.mmcm_locked = 1'b1;
    exp_n(5, vec(1'b0, 1'b0, 1'b0, 4'd0, 8'd1), "t3_lock_high");
    drain();
    bus.mmcm_locked = 1'b0;
    exp_n(3, vec(1'b0, 1'b0, 1'b0, 4'd0, 8'd1), "t3_glitch_low");
    drain();
    bus.mmcm_locked = 1'b1;
    exp_n(10, vec(1'b0, 1'b0, 1'b0, 4'd0, 8'd1), "t3_restable");
    exp_n(3,  vec(1'b0, 1'b1, 1'b0, 4'd0, 8'd1), "t3_run");
    drain();

    // 2: timeout and fail
    bus.soft_restart = 1'b1;
    bus.mmcm_locked  = 1'b0;
    exp_n(1, vec(1'b1, 1'b0, 1'b0, 4'd0, 8'd1), "t2_start");
    drain();
    bus.soft_restart = 1'b0;
    exp_n(3,  vec(1'b1, 1'b0, 1'b0, 4'd0, 8'd1), "t2_pulse0");
    exp_n(32, vec(1'b0, 1'b0, 1'b0, 4'd0, 8'd1), "t2_wait0");
    exp_n(4,  vec(1'b1, 1'b0, 1'b0, 4'd1, 8'd1), "t2_pulse1");
    exp_n(32, vec(1'b0, 1'b0, 1'b0, 4'd1, 8'd1), "t2_wait1");
    exp_n(4,  vec(1'b1, 1'b0, 1'b0, 4'd2, 8'd1), "t2_pulse2");
    exp_n(32, vec(1'b0, 1'b0, 1'b0, 4'd2, 8'd1), "t2_wait2");
    exp_n(3,  vec(1'b0, 1'b0, 1'b1, 4'd2, 8'd1), "t2_fail");
    drain();

    // 5a: soft_restart in FAIL
    bus.soft_restart = 1'b1;
    exp_n(1, vec(1'b1, 1'b0, 1'b0, 4'd0, 8'd1), "t5_soft_in_fail");
    drain();
    bus.soft_restart = 1'b0;
    exp_n(3, vec(1'b1, 1'b0, 1'b0, 4'd0, 8'd1), "t5_fail_restart_pulse");
    exp_n(1, vec(1'b0, 1'b0, 1'b0, 4'd0, 8'd1), "t5_wait");
    drain();
    bus.mmcm_locked = 1'b1;
    exp_n(4, vec(1'b0, 1'b0, 1'b0, 4'd0, 8'd1), "t6_into_stable");
    drain();

    // 6: rst_n beats soft_restart mid-STABLE
    rst_n            = 1'b0;
    bus.soft_restart = 1'b1;
    exp_n(1, vec(1'b1, 1'b0, 1'b0, 4'd0, 8'd0), "t6_reset_priority");
    drain();
    rst_n            = 1'b1;
    bus.soft_restart = 1'b0;
    exp_n(3, vec(1'b1, 1'b0, 1'b0, 4'd0, 8'd0), "t6_pulse");
    exp_n(9, vec(1'b0, 1'b0, 1'b0, 4'd0, 8'd0), "t6_wait_stable");
    exp_n(2, vec(1'b0, 1'b1, 1'b0, 4'd0, 8'd0), "t6_run");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
